// File: rtl/spi_txn_sequencer.sv
// ---------------------------------------------------------------------------
// spi_txn_sequencer
// Command-side sequencer sitting directly upstream of an SPI master control
// block. One command carries up to four write bytes and a total transaction
// length in bytes. The sequencer enables the master, watches its read fill
// level to count received bytes, packs them into 32-bit response words and
// drops the enable one byte early so the master stops on a byte boundary.
//
// Ports
//   clk_i, rstn_i            clock, synchronous active-low reset
//   cmd_*                    command channel (valid/ready), data/bytes/len
//   rsp_*                    response channel (valid/ready), data/bytes/last
//   err_o                    sticky error: overrun, stop timeout, zero length
//   spi_enable_o             enable to the master
//   spi_write_data_o/bytes_o latched write word and byte count to the master
//   spi_read_data_i          read word from the master
//   spi_read_bytes_valid_i   read fill level (0 = master idle)
// ---------------------------------------------------------------------------
module spi_txn_sequencer #(
   parameter int unsigned LEN_W        = 8,
   parameter int unsigned START_HOLD   = 12,
   parameter int unsigned STOP_TIMEOUT = 64
) (
   input  logic             clk_i,
   input  logic             rstn_i,
   input  logic             cmd_valid_i,
   output logic             cmd_ready_o,
   input  logic [31:0]      cmd_wr_data_i,
   input  logic [2:0]       cmd_wr_bytes_i,
   input  logic [LEN_W-1:0] cmd_len_i,
   output logic             rsp_valid_o,
   input  logic             rsp_ready_i,
   output logic [31:0]      rsp_data_o,
   output logic [2:0]       rsp_bytes_o,
   output logic             rsp_last_o,
   output logic             err_o,
   output logic             spi_enable_o,
   output logic [31:0]      spi_write_data_o,
   output logic [2:0]       spi_write_bytes_o,
   input  logic [31:0]      spi_read_data_i,
   input  logic [2:0]       spi_read_bytes_valid_i
);

   localparam int unsigned HOLD_W = (START_HOLD   > 1) ? $clog2(START_HOLD)   : 1;
   localparam int unsigned TO_W   = (STOP_TIMEOUT > 1) ? $clog2(STOP_TIMEOUT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_STOP,
      S_FLUSH
   } state_e;

   state_e             state_q,     state_d;
   logic [31:0]        wr_data_q,   wr_data_d;
   logic [2:0]         wr_bytes_q,  wr_bytes_d;
   logic [LEN_W-1:0]   len_q,       len_d;
   logic [LEN_W-1:0]   rx_cnt_q,    rx_cnt_d;
   logic [HOLD_W-1:0]  hold_cnt_q,  hold_cnt_d;
   logic [TO_W-1:0]    to_cnt_q,    to_cnt_d;
   logic [2:0]         prev_rbv_q,  prev_rbv_d;
   logic [31:0]        rx_buf_q,    rx_buf_d;
   logic [2:0]         pend_q,      pend_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [31:0]        rsp_data_q,  rsp_data_d;
   logic [2:0]         rsp_bytes_q, rsp_bytes_d;
   logic               rsp_last_q,  rsp_last_d;
   logic               err_q,       err_d;

   logic               capture;
   logic [LEN_W-1:0]   len_m1;
   logic [31:0]        flush_word;

   // NOTE: every signal assigned in this block gets a default first, so no
   // path through the case statement can leave one unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      wr_data_d    = wr_data_q;
      wr_bytes_d   = wr_bytes_q;
      len_d        = len_q;
      rx_cnt_d     = rx_cnt_q;
      hold_cnt_d   = hold_cnt_q;
      to_cnt_d     = to_cnt_q;
      prev_rbv_d   = spi_read_bytes_valid_i;
      rx_buf_d     = rx_buf_q;
      pend_d       = pend_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_bytes_d  = rsp_bytes_q;
      rsp_last_d   = rsp_last_q;
      err_d        = err_q;
      spi_enable_o = 1'b0;
      len_m1       = len_q - 1'b1;
      flush_word   = '0;

      // Only the active phases of a transaction watch the master's fill level.
      capture = (state_q == S_START || state_q == S_RUN || state_q == S_STOP) &&
                (spi_read_bytes_valid_i != 3'd0) &&
                (spi_read_bytes_valid_i != prev_rbv_q);

      for (int i = 0; i < 4; i++) begin
         if (3'(i) < pend_q) flush_word[8*i +: 8] = rx_buf_q[8*i +: 8];
      end

      if (rsp_valid_q && rsp_ready_i) rsp_valid_d = 1'b0;

      if (capture) begin
         if (rx_cnt_q != {LEN_W{1'b1}}) rx_cnt_d = rx_cnt_q + 1'b1;
         rx_buf_d = spi_read_data_i;
         pend_d   = spi_read_bytes_valid_i;
         if (spi_read_bytes_valid_i == 3'd4) begin
            // A full word still waiting unconsumed is lost: flag overrun.
            if (rsp_valid_q && !rsp_ready_i) err_d = 1'b1;
            pend_d      = 3'd0;
            rsp_valid_d = 1'b1;
            rsp_data_d  = spi_read_data_i;
            rsp_bytes_d = 3'd4;
            rsp_last_d  = 1'b0;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (cmd_valid_i) begin
               if (cmd_len_i == '0) begin
                  err_d = 1'b1;
               end else begin
                  wr_data_d  = cmd_wr_data_i;
                  wr_bytes_d = (cmd_wr_bytes_i > 3'd4) ? 3'd4 : cmd_wr_bytes_i;
                  len_d      = cmd_len_i;
                  rx_cnt_d   = '0;
                  hold_cnt_d = '0;
                  pend_d     = 3'd0;
                  state_d    = S_START;
               end
            end
         end
         S_START: begin
            spi_enable_o = 1'b1;
            if (hold_cnt_q == HOLD_W'(START_HOLD - 1)) state_d = S_RUN;
            else                                       hold_cnt_d = hold_cnt_q + 1'b1;
         end
         S_RUN: begin
            // Enable drops while the last byte is in flight, so the master
            // completes exactly that byte and then stops.
            if (rx_cnt_q >= len_m1) begin
               to_cnt_d = '0;
               state_d  = S_STOP;
            end else begin
               spi_enable_o = 1'b1;
            end
         end
         S_STOP: begin
            if (spi_read_bytes_valid_i == 3'd0) begin
               state_d = S_FLUSH;
            end else if (to_cnt_q == TO_W'(STOP_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_FLUSH;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         S_FLUSH: begin
            if (rsp_valid_q && rsp_last_q) begin
               // Final partial word presented; leave once it is taken.
               if (rsp_ready_i) state_d = S_IDLE;
            end else if (pend_q != 3'd0) begin
               // Wait for any full word still held before loading the tail.
               if (!rsp_valid_q || rsp_ready_i) begin
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = flush_word;
                  rsp_bytes_d = pend_q;
                  rsp_last_d  = 1'b1;
                  pend_d      = 3'd0;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of block ordering.
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q     <= S_IDLE;
         wr_data_q   <= '0;
         wr_bytes_q  <= '0;
         len_q       <= '0;
         rx_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         to_cnt_q    <= '0;
         prev_rbv_q  <= '0;
         rx_buf_q    <= '0;
         pend_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_bytes_q <= '0;
         rsp_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_data_q   <= wr_data_d;
         wr_bytes_q  <= wr_bytes_d;
         len_q       <= len_d;
         rx_cnt_q    <= rx_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         to_cnt_q    <= to_cnt_d;
         prev_rbv_q  <= prev_rbv_d;
         rx_buf_q    <= rx_buf_d;
         pend_q      <= pend_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_bytes_q <= rsp_bytes_d;
         rsp_last_q  <= rsp_last_d;
         err_q       <= err_d;
      end
   end

   assign cmd_ready_o       = (state_q == S_IDLE);
   assign rsp_valid_o       = rsp_valid_q;
   assign rsp_data_o        = rsp_data_q;
   assign rsp_bytes_o       = rsp_bytes_q;
   assign rsp_last_o        = rsp_last_q;
   assign err_o             = err_q;
   assign spi_write_data_o  = wr_data_q;
   assign spi_write_bytes_o = wr_bytes_q;

endmodule
